uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with transmit FIFO; define UART_TX_PARITY_EN to add an
// even-parity bit between DATA and STOP.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 overflow,
    output logic                 tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = 4;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
    localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 tx_q, tx_n;
    logic                 pop;
    logic                 push;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 par, par_n;
`endif

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic [AW:0]          count;
    logic [DATA_BITS-1:0] head;

    assign full     = (count == DEPTH);
    assign empty    = (count == '0);
    assign push     = wr_en & ~full;
    assign head     = mem[rptr];
    assign busy     = (state != IDLE);
    assign tx       = tx_q;
    assign bit_end  = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        tx_n    = tx_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        if (state != IDLE) cnt_n = bit_end ? '0 : cnt + 1'b1;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                    cnt_n   = '0;
                    tx_n    = 1'b0;
                    shreg_n = head;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^head;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    idx_n   = '0;
                    tx_n    = shreg[0];
                    shreg_n = {1'b0, shreg[DATA_BITS-1:1]};
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = par;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
                        idx_n   = '0;
`endif
                    end else begin
                        idx_n   = idx + 1'b1;
                        tx_n    = shreg[0];
                        shreg_n = {1'b0, shreg[DATA_BITS-1:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                    idx_n   = '0;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (idx != STOP_LAST) begin
                        idx_n = idx + 1'b1;
                    end else if (!empty) begin
                        // back-to-back frame: no idle gap
                        pop     = 1'b1;
                        state_n = START;
                        tx_n    = 1'b0;
                        shreg_n = head;
`ifdef UART_TX_PARITY_EN
                        par_n   = ^head;
`endif
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            tx_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            tx_q  <= tx_n;
`ifdef UART_TX_PARITY_EN
            par   <= par_n;
`endif
        end
    end

endmodule
